// File: rtl/tpm_ram_pkg.sv
// rtl/tpm_ram_pkg.sv - shared constants and helpers for the TPM command/response RAM arbiter
package tpm_ram_pkg;

    localparam int RAM_AW = 9;
    localparam int RAM_DW = 32;
    localparam int LPC_AW = 11;

    localparam logic [7:0] LOCK_READ_VAL = 8'hFF;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_LPC_RESP = 2'd1;
    localparam logic [1:0] ST_WB_RESP  = 2'd2;

    function automatic logic [3:0] lane_onehot(input logic [1:0] lane);
        return 4'b0001 << lane;
    endfunction

endpackage

// File: rtl/tpm_ram_lane.sv
// rtl/tpm_ram_lane.sv - byte-lane encode (one-hot enable, replicated byte) and decode (byte select)
module tpm_ram_lane
    import tpm_ram_pkg::*;
(
    input  logic [1:0]        wr_lane,
    input  logic [7:0]        wr_byte,
    output logic [3:0]        wr_wen,
    output logic [RAM_DW-1:0] wr_word,
    input  logic [1:0]        rd_lane,
    input  logic [RAM_DW-1:0] rd_word,
    output logic [7:0]        rd_byte
);

    assign wr_wen  = lane_onehot(wr_lane);
    assign wr_word = {4{wr_byte}};
    assign rd_byte = rd_word[8*rd_lane +: 8];

endmodule

// File: rtl/tpm_ram_arbiter.sv
// rtl/tpm_ram_arbiter.sv - LPC/Wishbone arbiter for the 512x32 TPM RAM; optional TPM_RAM_LOCK_EN
module tpm_ram_arbiter
    import tpm_ram_pkg::*;
#(
    parameter int LPC_MAX_CONSEC = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              lpc_req_i,
    input  logic              lpc_we_i,
    input  logic [LPC_AW-1:0] lpc_addr_i,
    input  logic [7:0]        lpc_wdata_i,
    output logic [7:0]        lpc_rdata_o,
    output logic              lpc_done_o,
    input  logic              WBs_CYC,
    input  logic              WBs_STB,
    input  logic              WBs_WE,
    input  logic [16:0]       WBs_ADR,
    input  logic [3:0]        WBs_BYTE_STB,
    input  logic [RAM_DW-1:0] WBs_WR_DAT,
    output logic [RAM_DW-1:0] WBs_RD_DAT,
    output logic              WBs_ACK,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [RAM_DW-1:0] ram_wdata_o,
    output logic [3:0]        ram_wen_o,
    output logic              ram_wr_en_o,
    output logic              ram_rd_en_o,
    input  logic [RAM_DW-1:0] ram_rdata_i
`ifdef TPM_RAM_LOCK_EN
    ,
    input  logic              lpc_lock_i,
    output logic              lock_viol_o
`endif
);

    logic [1:0]        state_q;
    logic [3:0]        consec_q;
    logic [1:0]        rd_lane_q;
    logic              locked_q;
    logic              wb_req;
    logic              cap_hit;
    logic              in_idle;
    logic              wb_win;
    logic              lpc_win;
    logic              lpc_ram_ok;
    logic              lock_now;
    logic              lpc_resp;
    logic [3:0]        lane_wen;
    logic [RAM_DW-1:0] lane_word;
    logic [7:0]        lane_byte;
    logic              unused_adr;

    assign unused_adr = ^{WBs_ADR[16:11], WBs_ADR[1:0]};

`ifdef TPM_RAM_LOCK_EN
    assign lock_now = lpc_lock_i;
`else
    assign lock_now = 1'b0;
`endif

    // LPC wins ties unless it has already taken LPC_MAX_CONSEC grants over a waiting WB master
    assign wb_req     = WBs_CYC & WBs_STB;
    assign cap_hit    = (consec_q == 4'(LPC_MAX_CONSEC));
    assign in_idle    = (state_q == ST_IDLE) & ~rst_i;
    assign wb_win     = in_idle & wb_req & (~lpc_req_i | cap_hit);
    assign lpc_win    = in_idle & lpc_req_i & ~wb_win;
    assign lpc_ram_ok = lpc_win & ~lock_now;

    tpm_ram_lane u_lane (
        .wr_lane (lpc_addr_i[1:0]),
        .wr_byte (lpc_wdata_i),
        .wr_wen  (lane_wen),
        .wr_word (lane_word),
        .rd_lane (rd_lane_q),
        .rd_word (ram_rdata_i),
        .rd_byte (lane_byte)
    );

    always_comb begin
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_wen_o   = '0;
        ram_wr_en_o = 1'b0;
        ram_rd_en_o = 1'b0;
        if (lpc_ram_ok) begin
            ram_addr_o = lpc_addr_i[LPC_AW-1:2];
            if (lpc_we_i) begin
                ram_wdata_o = lane_word;
                ram_wen_o   = lane_wen;
                ram_wr_en_o = 1'b1;
            end else begin
                ram_rd_en_o = 1'b1;
            end
        end else if (wb_win) begin
            ram_addr_o = WBs_ADR[10:2];
            if (WBs_WE) begin
                ram_wdata_o = WBs_WR_DAT;
                ram_wen_o   = WBs_BYTE_STB;
                ram_wr_en_o = |WBs_BYTE_STB;
            end else begin
                ram_rd_en_o = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            consec_q  <= '0;
            rd_lane_q <= '0;
            locked_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (lpc_win) begin
                        state_q   <= ST_LPC_RESP;
                        rd_lane_q <= lpc_addr_i[1:0];
                        locked_q  <= lock_now;
                    end else if (wb_win) begin
                        state_q <= ST_WB_RESP;
                    end
                    if (wb_win || !wb_req) begin
                        consec_q <= '0;
                    end else if (lpc_win) begin
                        consec_q <= consec_q + 4'd1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Response outputs are gated by reset so an access interrupted by reset never completes
    assign lpc_resp    = (state_q == ST_LPC_RESP) & ~rst_i;
    assign lpc_done_o  = lpc_resp;
    assign lpc_rdata_o = !lpc_resp ? 8'h00 : (locked_q ? LOCK_READ_VAL : lane_byte);
    assign WBs_ACK     = (state_q == ST_WB_RESP) & ~rst_i;
    assign WBs_RD_DAT  = WBs_ACK ? ram_rdata_i : '0;

`ifdef TPM_RAM_LOCK_EN
    assign lock_viol_o = lpc_resp & locked_q;
`endif

endmodule
